// File: rtl/avalon_slave_uart.sv
// Avalon-MM slave UART (8N1) with TX/RX FIFOs, sticky error flags and a level interrupt.
// Optional internal loopback on CONTROL[2] is built only when AVS_UART_LOOPBACK_EN is defined.

module avalon_slave_uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

module avalon_slave_uart #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_irq,
  output logic        rs232_tx,
  input  logic        rs232_rx
);
  localparam int DIVISOR = CLK_FREQ / BAUD;
  localparam int CW      = $clog2(DIVISOR);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
`ifdef AVS_UART_LOOPBACK_EN
  localparam int CTRL_W = 3;
`else
  localparam int CTRL_W = 2;
`endif

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t   tx_state, tx_state_n;
  rx_state_t   rx_state, rx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n, rx_bit, rx_bit_n;
  logic [7:0]  tx_sh, tx_sh_n, rx_sh, rx_sh_n, tx_head, rx_head;
  logic        tx_pop, tx_line, tx_full, tx_empty, tx_busy;
  logic        rx_push, rx_full, rx_empty, rx_avail, rx_wait, rx_wait_n, ferr_set;
  logic        rx_in, rx_s1, rx_s2, rx_s3, rx_fall;
  logic        rx_overrun, frame_err, loopback;
  logic        data_wr, data_rd, status_wr;
  logic [CTRL_W-1:0] ctrl;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  assign unused_wdata = ^avs_writedata[31:8];
  assign data_wr   = avs_write && (avs_address == 2'd0);
  assign data_rd   = avs_read  && (avs_address == 2'd0);
  assign status_wr = avs_write && (avs_address == 2'd1);
  assign tx_busy   = (tx_state != TX_IDLE);
  assign rx_avail  = !rx_empty;

`ifdef AVS_UART_LOOPBACK_EN
  assign loopback = ctrl[2];
`else
  assign loopback = 1'b0;
`endif
  assign rs232_tx = loopback ? 1'b1 : tx_line;
  assign rx_in    = loopback ? tx_line : rs232_rx;

  avalon_slave_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push(data_wr), .pop(tx_pop), .din(avs_writedata[7:0]),
    .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );

  avalon_slave_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push(rx_push), .pop(data_rd), .din(rx_sh),
    .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // Transmitter: line level is decoded from state so reset forces it high at once.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_pop     = 1'b0;
    tx_line    = 1'b1;
    case (tx_state)
      TX_IDLE: if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_sh_n    = tx_head;
        tx_cnt_n   = '0;
        tx_state_n = TX_START;
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n   = '0;
          tx_bit_n   = 3'd0;
          tx_state_n = TX_DATA;
        end else tx_cnt_n = tx_cnt + CNT_ONE;
      end
      TX_DATA: begin
        tx_line = tx_sh[0];
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          tx_sh_n  = {1'b0, tx_sh[7:1]};
          if (tx_bit == 3'd7) tx_state_n = TX_STOP;
          else tx_bit_n = tx_bit + 3'd1;
        end else tx_cnt_n = tx_cnt + CNT_ONE;
      end
      TX_STOP: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_IDLE;
        end else tx_cnt_n = tx_cnt + CNT_ONE;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  assign rx_fall = rx_s3 && !rx_s2;

  // Receiver: samples mid-bit, counting from the synced falling edge of the start bit.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_wait_n  = rx_wait;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_fall) begin
        rx_cnt_n   = '0;
        rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == CNT_HALF) begin
          rx_cnt_n   = '0;
          rx_bit_n   = 3'd0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end else rx_cnt_n = rx_cnt + CNT_ONE;
      end
      RX_DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s2, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else rx_bit_n = rx_bit + 3'd1;
        end else rx_cnt_n = rx_cnt + CNT_ONE;
      end
      RX_STOP: begin
        if (rx_wait) begin
          if (rx_s2) begin
            rx_wait_n  = 1'b0;
            rx_state_n = RX_IDLE;
          end
        end else if (rx_cnt == CNT_LAST) begin
          rx_cnt_n = '0;
          if (rx_s2) begin
            rx_push    = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            ferr_set  = 1'b1;
            rx_wait_n = 1'b1;
          end
        end else rx_cnt_n = rx_cnt + CNT_ONE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_sh    <= 8'd0;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_sh    <= 8'd0;
      rx_wait  <= 1'b0;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
      rx_wait  <= rx_wait_n;
      rx_s1    <= rx_in;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      2'd0: rd_mux = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_head};
      2'd1: rd_mux = {26'd0, frame_err, tx_busy, rx_overrun, rx_avail, tx_empty, tx_full};
      2'd2: rd_mux = {{(32 - CTRL_W){1'b0}}, ctrl};
      default: rd_mux = '0;
    endcase
  end

  // Sticky flags: a new error event wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl         <= '0;
      rx_overrun   <= 1'b0;
      frame_err    <= 1'b0;
      avs_readdata <= '0;
      avs_irq      <= 1'b0;
    end else begin
      if (avs_write && (avs_address == 2'd2)) ctrl <= avs_writedata[CTRL_W-1:0];
      if (rx_push && rx_full && !data_rd) rx_overrun <= 1'b1;
      else if (status_wr && avs_writedata[3]) rx_overrun <= 1'b0;
      if (ferr_set) frame_err <= 1'b1;
      else if (status_wr && avs_writedata[5]) frame_err <= 1'b0;
      avs_readdata <= avs_read ? rd_mux : 32'd0;
      avs_irq <= (ctrl[0] && rx_avail) || (ctrl[1] && tx_empty && !tx_busy) ||
                 rx_overrun || frame_err;
    end
  end
endmodule

// File: tb/tb_avalon_slave_uart.sv
// Directed bench for avalon_slave_uart: expected read data and TX frames are queued by the
// stimulus and consumed by independent monitors on the bus and serial line.

module tb_avalon_slave_uart;
  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        avs_irq;
  logic        rs232_tx;
  logic        rs232_rx = 1'b1;

  int checks = 0;
  int errors = 0;
  int tx_frames = 0;
  logic        rd_fire = 1'b0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [7:0]  exp_tx_q[$];

  avalon_slave_uart #(.CLK_FREQ(1000000), .BAUD(100000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_irq(avs_irq), .rs232_tx(rs232_tx), .rs232_rx(rs232_rx)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Driver tasks: called at a negedge, return at a later negedge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    avs_address = a;
    avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rs232_rx = 1'b0;
    idle(DIV);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = b[i];
      idle(DIV);
    end
    rs232_rx = stop_bit;
    idle(DIV);
    rs232_rx = 1'b1;
  endtask

  // Bus monitor: read data is due the cycle after the read strobe.
  always @(posedge clk) rd_fire <= avs_read;

  always @(negedge clk) begin
    if (rd_fire) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_unexpected: got 0x%0h expected no read", avs_readdata);
      end else begin
        check(name_q.pop_front(), avs_readdata, exp_q.pop_front());
      end
    end
  end

  // Serial monitor: checks every clock of each frame against the queued byte.
  always begin
    logic [7:0] exp_b, got;
    logic       lvl, aborted, unexpected;
    int         bad;
    @(negedge clk);
    if (reset_n && rs232_tx === 1'b0) begin
      unexpected = (exp_tx_q.size() == 0);
      exp_b = unexpected ? 8'h00 : exp_tx_q.pop_front();
      got = 8'h00;
      bad = 0;
      aborted = 1'b0;
      for (int c = 0; c < 100; c++) begin
        if (!reset_n) begin
          aborted = 1'b1;
          break;
        end
        if (c < 10) lvl = 1'b0;
        else if (c < 90) lvl = exp_b[(c - 10) / 10];
        else lvl = 1'b1;
        if (rs232_tx !== lvl) bad++;
        if (c >= 10 && c < 90 && (c % 10) == 5) got[(c - 10) / 10] = rs232_tx;
        if (c < 99) @(negedge clk);
      end
      if (unexpected) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected_frame: got byte 0x%0h expected no frame", got);
      end else if (!aborted) begin
        tx_frames++;
        check("tx_frame", {23'd0, bad != 0, got}, {24'd0, exp_b});
      end
    end
  end

  initial begin
    int  lows;
    logic seen_irq;
    idle(3);
    reset_n = 1'b1;
    idle(1);
    check("reset_tx", {31'd0, rs232_tx}, 32'd1);
    check("reset_irq", {31'd0, avs_irq}, 32'd0);
    check("reset_readdata", avs_readdata, 32'd0);
    bus_read(2'd1, 32'h02, "reset_status");
    bus_read(2'd2, 32'h00, "reset_control");
    bus_read(2'd3, 32'h00, "reg3_read");
    bus_read(2'd0, 32'h00, "data_empty");

    // Single TX frame 0x55; busy during the frame, idle after
    exp_tx_q.push_back(8'h55);
    bus_write(2'd0, 32'h55);
    idle(20);
    bus_read(2'd1, 32'h12, "status_tx_busy");
    idle(100);
    bus_read(2'd1, 32'h02, "status_tx_done");

    // RX frame 0xA3
    send_frame(8'hA3, 1'b1);
    idle(2);
    bus_read(2'd1, 32'h06, "status_rx_avail");
    bus_read(2'd0, 32'h1A3, "rx_data_a3");
    bus_read(2'd0, 32'h000, "rx_data_empty");

    // Six back-to-back writes into a 4-deep FIFO: the sixth is dropped
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) exp_tx_q.push_back(8'(i));
      bus_write(2'd0, 32'(i));
    end
    bus_read(2'd1, 32'h11, "status_tx_full");
    idle(520);
    bus_read(2'd1, 32'h02, "status_tx_drained");

    // Five RX frames, no reads: overrun
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1);
    idle(2);
    bus_read(2'd1, 32'h0E, "status_overrun");
    check("irq_overrun", {31'd0, avs_irq}, 32'd1);
    bus_write(2'd1, 32'h08);
    bus_read(2'd1, 32'h06, "status_overrun_clr");
    check("irq_overrun_clr", {31'd0, avs_irq}, 32'd0);
    for (int i = 0; i < 4; i++) bus_read(2'd0, 32'h110 + 32'(i), "rx_fifo_order");
    bus_read(2'd0, 32'h000, "rx_fifo_empty");

    // Bad stop bit
    send_frame(8'h5A, 1'b0);
    idle(5);
    bus_read(2'd1, 32'h22, "status_frame_err");
    check("irq_frame_err", {31'd0, avs_irq}, 32'd1);
    bus_write(2'd1, 32'h20);
    bus_read(2'd1, 32'h02, "status_ferr_clr");
    bus_read(2'd0, 32'h000, "ferr_no_push");

    // 3-clock glitch
    rs232_rx = 1'b0;
    idle(3);
    rs232_rx = 1'b1;
    idle(30);
    bus_read(2'd1, 32'h02, "status_glitch");
    bus_read(2'd0, 32'h000, "glitch_no_push");

    // CONTROL and interrupt enables
    bus_write(2'd2, 32'h4);
`ifdef AVS_UART_LOOPBACK_EN
    bus_read(2'd2, 32'h4, "control_bit2");
`else
    bus_read(2'd2, 32'h0, "control_bit2");
`endif
    bus_write(2'd2, 32'h2);
    idle(1);
    check("irq_tx_empty", {31'd0, avs_irq}, 32'd1);
    bus_write(2'd2, 32'h1);
    idle(1);
    check("irq_rx_en_no_data", {31'd0, avs_irq}, 32'd0);
    bus_read(2'd2, 32'h1, "control_readback");
    bus_write(2'd2, 32'h0);

`ifdef AVS_UART_LOOPBACK_EN
    bus_write(2'd2, 32'h5);
    bus_write(2'd0, 32'h3C);
    lows = 0;
    seen_irq = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (rs232_tx !== 1'b1) lows++;
      if (avs_irq === 1'b1) seen_irq = 1'b1;
      @(negedge clk);
    end
    check("loopback_tx_held", 32'(lows), 32'd0);
    check("loopback_irq", {31'd0, seen_irq}, 32'd1);
    bus_read(2'd0, 32'h13C, "loopback_data");
    bus_write(2'd2, 32'h0);
    idle(2);
`endif

    // Reset in the middle of a frame
    bus_write(2'd2, 32'h3);
    exp_tx_q.push_back(8'h00);
    bus_write(2'd0, 32'h00);
    idle(15);
    check("tx_low_mid_frame", {31'd0, rs232_tx}, 32'd0);
    #2 reset_n = 1'b0;
    #1 check("tx_async_reset", {31'd0, rs232_tx}, 32'd1);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    bus_read(2'd1, 32'h02, "status_after_reset");
    bus_read(2'd2, 32'h00, "control_after_reset");
    idle(120);

    check("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_q.size()), 32'd0);
    check("tx_frame_count", 32'(tx_frames), 32'd6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/avalon_slave_uart.md
Name: avalon_slave_uart

Overview:
- Avalon-MM slave UART peripheral, 8N1, with TX and RX FIFOs and an interrupt output.
- The on-chip CPU (Avalon master) writes bytes for transmission and reads received bytes over a register interface.
- It is the responder side of the Avalon bus, the opposite end from the UART-driven Avalon master.
- It shares the system clock and reset, and exports its rs232 rx/tx conduit pins to the top level.

Parameters:
- CLK_FREQ, 50000000, clock frequency in Hz.
- BAUD, 115200, line rate; DIVISOR = CLK_FREQ/BAUD (integer, truncated) clocks per bit, minimum 4.
- FIFO_DEPTH, 16, entries per FIFO; power of 2, from 2 to 256.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- avs_address  in  2  word register index.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, registered, read latency 1.
- avs_irq  out  1  level interrupt.
- rs232_tx  out  1  serial output; idles high.
- rs232_rx  in  1  serial input, asynchronous.

Behaviour:
- Reset: all FIFOs empty, FSMs IDLE, avs_readdata=0, avs_irq=0, rs232_tx=1, CONTROL=0, sticky flags cleared. Reset mid-frame aborts the frame immediately; tx returns to 1 asynchronously.
- There is no waitrequest. Every access completes in 1 cycle; avs_readdata is valid the cycle after avs_read.
- Reg 0 DATA, write: push writedata[7:0] into the TX FIFO. If the TX FIFO is full, the write is dropped silently.
- Reg 0 DATA, read: returns {23'b0, valid, byte}. If the RX FIFO is non-empty, valid=1 and the head is popped in the read cycle. If empty, it returns 0 and nothing is popped.
- Reg 1 STATUS, read bits: [0] tx_full, [1] tx_empty, [2] rx_avail, [3] rx_overrun (sticky), [4] tx_busy (FSM not IDLE), [5] frame_err (sticky). Writing 1 to bit 3 or bit 5 clears that flag.
- Reg 2 CONTROL, read/write bits: [0] rx_irq_en, [1] tx_irq_en, [2] loopback (only with the optional feature); other bits read 0.
- Reg 3: reads 0; writes are ignored.
- avs_irq = (rx_irq_en & rx_avail) | (tx_irq_en & tx_empty & ~tx_busy) | rx_overrun | frame_err. It is registered, so it changes 1 cycle after its cause.
- TX FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop it, load the shifter, go to START.
  - START: tx=0 for DIVISOR cycles.
  - DATA: 8 bits, LSB first, DIVISOR cycles each.
  - STOP: tx=1 for DIVISOR cycles, then IDLE. IDLE pops again the next cycle, so back-to-back frames have no extra idle bit beyond 1 clk.
- RX input: passes through a 2-flop synchronizer before any use.
- RX FSM states and transitions:
  - IDLE: on a synced falling edge, go to START.
  - START: at DIVISOR/2 re-sample; if 1 the start bit was a glitch, return to IDLE; if 0 go to DATA.
  - DATA: sample 8 bits at DIVISOR intervals from mid-start.
  - STOP: sample at mid-bit. If 1, push the byte. If 0, discard the byte, set frame_err, and wait in STOP until the line is 1 before returning to IDLE.
- RX push with FIFO full and no same-cycle pop: the byte is dropped and rx_overrun is set. A same-cycle pop and push when full: both succeed, no overrun.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full is when the pointers differ only in the MSB.
- Simultaneous bus write to DATA and TX FSM pop from the same FIFO: both happen; the count is unchanged.

Optional Feature:
- Macro: AVS_UART_LOOPBACK_EN.
- With the macro defined: CONTROL[2] is implemented. When it is 1, the RX synchronizer input is the internal TX line instead of rs232_rx, and rs232_tx is held at 1.
- Without the macro: CONTROL[2] reads 0 and its writes are ignored; RX always uses rs232_rx.

Test Plan (CLK_FREQ=1000000, BAUD=100000, DIVISOR=10, FIFO_DEPTH=4):
- Write DATA=0x55 -> rs232_tx is low 10 clk, then bits 1,0,1,0,1,0,1,0 at 10 clk each, then high 10 clk. tx_busy=1 throughout the frame, 0 after.
- Drive rs232_rx with frame 0xA3 -> STATUS[2]=1. Read DATA returns 0x1A3, then a second read returns 0x000.
- Write 6 bytes back-to-back -> the first is popped at once, leaving 3 in the FIFO plus one accepted. tx_full=1; the 6th byte is dropped; exactly 5 frames are transmitted.
- Send 5 RX frames with no reads -> 4 are stored and rx_overrun=1, avs_irq=1. Write STATUS=0x8 clears the flag; the 4 bytes are read back in order.
- RX frame with stop bit=0 -> no push and frame_err=1. A 3-clk low glitch on rx -> no frame received and no flag set.
- With AVS_UART_LOOPBACK_EN and CONTROL=0x5: write 0x3C -> it is received as 0x13C, avs_irq rises, and rs232_tx stays 1.
